// File: rtl/my_ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and the shared 512x16 RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface my_ram_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              owner;
    logic [DATA_W-1:0] ram_in;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        output ack0, ack1, rdata0, rdata1, busy, owner, ram_in, ram_addr, ram_load
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_out,
        input  ack0, ack1, rdata0, rdata1, busy, owner, ram_in, ram_addr, ram_load
    );
endinterface

// File: rtl/my_ram_arbiter.sv
// Two-port round-robin arbiter for a shared 512x16 RAM. Each access takes
// IDLE -> GRANT -> ACK, with the RAM pins driven only during GRANT.
module my_ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    my_ram_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t state;
    logic   winner;

    // Pick the requester to serve: a lone request wins, a tie goes to the non-owner.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~bus.owner;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    // Sequencer: latch the winner's access, drive the RAM one cycle, then pulse its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
            bus.ram_load <= 1'b0;
            bus.ram_addr <= '0;
            bus.ram_in   <= '0;
            bus.busy     <= 1'b0;
            bus.owner    <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.ack0     <= 1'b0;
                    bus.ack1     <= 1'b0;
                    bus.ram_load <= 1'b0;
                    if (bus.req0 || bus.req1) begin
                        bus.owner    <= winner;
                        bus.busy     <= 1'b1;
                        bus.ram_load <= winner ? bus.we1    : bus.we0;
                        bus.ram_addr <= winner ? bus.addr1  : bus.addr0;
                        bus.ram_in   <= winner ? bus.wdata1 : bus.wdata0;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    bus.ram_load <= 1'b0;
                    if (!bus.ram_load) begin
                        if (bus.owner) begin
                            bus.rdata1 <= bus.ram_out;
                        end else begin
                            bus.rdata0 <= bus.ram_out;
                        end
                    end
                    if (bus.owner) begin
                        bus.ack1 <= 1'b1;
                    end else begin
                        bus.ack0 <= 1'b1;
                    end
                    state <= ACK;
                end
                ACK: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_ram_arbiter.sv
// Bench for my_ram_arbiter: behavioural 512x16 RAM, a cycle-by-cycle vector
// table, and hand-written round-robin and reset-in-flight sequences.
module tb_my_ram_arbiter;

    logic clk;
    logic reset;

    my_ram_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    my_ram_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Shared RAM: write on rising clk when load is high, combinational read.
    logic [15:0] mem [512];

    // RAM write port, which has no reset.
    always @(posedge clk) begin
        if (bus.ram_load) mem[bus.ram_addr] <= bus.ram_in;
    end

    assign bus.ram_out = mem[bus.ram_addr];

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        rst;
        logic        r0;
        logic        w0;
        logic [8:0]  a0;
        logic [15:0] d0;
        logic        r1;
        logic        w1;
        logic [8:0]  a1;
        logic [15:0] d1;
        logic        eAck0;
        logic        eAck1;
        logic        eBusy;
        logic        eOwner;
        logic        eLoad;
        logic [8:0]  eAddr;
        logic [15:0] eIn;
        logic [15:0] eRd0;
        logic [15:0] eRd1;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    int nCompared;
    int nMismatched;

    function automatic vec_t mk(
        input logic rst,
        input logic r0, input logic w0, input logic [8:0] a0, input logic [15:0] d0,
        input logic r1, input logic w1, input logic [8:0] a1, input logic [15:0] d1,
        input logic eAck0, input logic eAck1, input logic eBusy, input logic eOwner,
        input logic eLoad, input logic [8:0] eAddr, input logic [15:0] eIn,
        input logic [15:0] eRd0, input logic [15:0] eRd1);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eAck0 = eAck0; v.eAck1 = eAck1; v.eBusy = eBusy; v.eOwner = eOwner;
        v.eLoad = eLoad; v.eAddr = eAddr; v.eIn = eIn; v.eRd0 = eRd0; v.eRd1 = eRd1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        bus.req0   = v.r0;
        bus.we0    = v.w0;
        bus.addr0  = v.a0;
        bus.wdata0 = v.d0;
        bus.req1   = v.r1;
        bus.we1    = v.w1;
        bus.addr1  = v.a1;
        bus.wdata1 = v.d1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ack0"},   32'(bus.ack0),     32'd0);
        checkOutput({tag, "_ack1"},   32'(bus.ack1),     32'd0);
        checkOutput({tag, "_busy"},   32'(bus.busy),     32'd0);
        checkOutput({tag, "_owner"},  32'(bus.owner),    32'd1);
        checkOutput({tag, "_load"},   32'(bus.ram_load), 32'd0);
        checkOutput({tag, "_addr"},   32'(bus.ram_addr), 32'd0);
        checkOutput({tag, "_in"},     32'(bus.ram_in),   32'd0);
        checkOutput({tag, "_rdata0"}, 32'(bus.rdata0),   32'd0);
        checkOutput({tag, "_rdata1"}, 32'(bus.rdata1),   32'd0);
    endtask

    // Main test sequence.
    initial begin
        int ackCycle [4];
        int ackOwner [4];
        int nAcks;
        bit seen;

        nCompared   = 0;
        nMismatched = 0;

        //            rst r0 w0 a0      d0        r1 w1 a1      d1       ak0 ak1 bsy own ld addr    in        rd0       rd1
        vecs[0]  = mk(0,  1, 1, 9'h005, 16'h1234, 0, 0, 9'h000, 16'h0,   0,  0,  1,  0,  1, 9'h005, 16'h1234, 16'h0,    16'h0);
        vecs[1]  = mk(0,  1, 1, 9'h005, 16'h1234, 0, 0, 9'h000, 16'h0,   1,  0,  1,  0,  0, 9'h005, 16'h0,    16'h0,    16'h0);
        vecs[2]  = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  0,  0, 9'h005, 16'h0,    16'h0,    16'h0);
        vecs[3]  = mk(0,  1, 0, 9'h005, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  1,  0,  0, 9'h005, 16'h0,    16'h0,    16'h0);
        vecs[4]  = mk(0,  1, 0, 9'h005, 16'h0,    0, 0, 9'h000, 16'h0,   1,  0,  1,  0,  0, 9'h005, 16'h0,    16'h1234, 16'h0);
        vecs[5]  = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  0,  0, 9'h005, 16'h0,    16'h1234, 16'h0);
        vecs[6]  = mk(1,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  1,  0, 9'h000, 16'h0,    16'h0,    16'h0);
        vecs[7]  = mk(0,  1, 1, 9'h000, 16'd2,    1, 1, 9'h1A7, 16'd9,   0,  0,  1,  0,  1, 9'h000, 16'd2,    16'h0,    16'h0);
        vecs[8]  = mk(0,  1, 1, 9'h000, 16'd2,    1, 1, 9'h1A7, 16'd9,   1,  0,  1,  0,  0, 9'h000, 16'h0,    16'h0,    16'h0);
        vecs[9]  = mk(0,  0, 0, 9'h000, 16'h0,    1, 1, 9'h1A7, 16'd9,   0,  0,  0,  0,  0, 9'h000, 16'h0,    16'h0,    16'h0);
        vecs[10] = mk(0,  0, 0, 9'h000, 16'h0,    1, 1, 9'h1A7, 16'd9,   0,  0,  1,  1,  1, 9'h1A7, 16'd9,    16'h0,    16'h0);
        vecs[11] = mk(0,  0, 0, 9'h000, 16'h0,    1, 1, 9'h1A7, 16'd9,   0,  1,  1,  1,  0, 9'h1A7, 16'h0,    16'h0,    16'h0);
        vecs[12] = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  1,  0, 9'h1A7, 16'h0,    16'h0,    16'h0);
        vecs[13] = mk(0,  1, 0, 9'h000, 16'h0,    1, 0, 9'h1A7, 16'h0,   0,  0,  1,  0,  0, 9'h000, 16'h0,    16'h0,    16'h0);
        vecs[14] = mk(0,  1, 0, 9'h000, 16'h0,    1, 0, 9'h1A7, 16'h0,   1,  0,  1,  0,  0, 9'h000, 16'h0,    16'd2,    16'h0);
        vecs[15] = mk(0,  0, 0, 9'h000, 16'h0,    1, 0, 9'h1A7, 16'h0,   0,  0,  0,  0,  0, 9'h000, 16'h0,    16'd2,    16'h0);
        vecs[16] = mk(0,  0, 0, 9'h000, 16'h0,    1, 0, 9'h1A7, 16'h0,   0,  0,  1,  1,  0, 9'h1A7, 16'h0,    16'd2,    16'h0);
        vecs[17] = mk(0,  0, 0, 9'h000, 16'h0,    1, 0, 9'h1A7, 16'h0,   0,  1,  1,  1,  0, 9'h1A7, 16'h0,    16'd2,    16'd9);
        vecs[18] = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  1,  0, 9'h1A7, 16'h0,    16'd2,    16'd9);
        vecs[19] = mk(0,  0, 0, 9'h000, 16'h0,    1, 1, 9'h1FF, 16'hAA,  0,  0,  1,  1,  1, 9'h1FF, 16'h00AA, 16'd2,    16'd9);
        vecs[20] = mk(0,  0, 0, 9'h000, 16'h0,    1, 1, 9'h1FF, 16'hAA,  0,  1,  1,  1,  0, 9'h1FF, 16'h0,    16'd2,    16'd9);
        vecs[21] = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  1,  0, 9'h1FF, 16'h0,    16'd2,    16'd9);
        vecs[22] = mk(0,  1, 1, 9'h000, 16'h55,   0, 0, 9'h000, 16'h0,   0,  0,  1,  0,  1, 9'h000, 16'h0055, 16'd2,    16'd9);
        vecs[23] = mk(0,  1, 1, 9'h000, 16'h55,   0, 0, 9'h000, 16'h0,   1,  0,  1,  0,  0, 9'h000, 16'h0,    16'd2,    16'd9);
        vecs[24] = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  0,  0, 9'h000, 16'h0,    16'd2,    16'd9);
        vecs[25] = mk(0,  1, 0, 9'h1FF, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  1,  0,  0, 9'h1FF, 16'h0,    16'd2,    16'd9);
        vecs[26] = mk(0,  1, 0, 9'h1FF, 16'h0,    0, 0, 9'h000, 16'h0,   1,  0,  1,  0,  0, 9'h1FF, 16'h0,    16'h00AA, 16'd9);
        vecs[27] = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  0,  0, 9'h1FF, 16'h0,    16'h00AA, 16'd9);
        vecs[28] = mk(0,  0, 0, 9'h000, 16'h0,    1, 0, 9'h000, 16'h0,   0,  0,  1,  1,  0, 9'h000, 16'h0,    16'h00AA, 16'd9);
        vecs[29] = mk(0,  0, 0, 9'h000, 16'h0,    1, 0, 9'h000, 16'h0,   0,  1,  1,  1,  0, 9'h000, 16'h0,    16'h00AA, 16'h0055);
        vecs[30] = mk(0,  0, 0, 9'h000, 16'h0,    0, 0, 9'h000, 16'h0,   0,  0,  0,  1,  0, 9'h000, 16'h0,    16'h00AA, 16'h0055);

        // Reset held two cycles with both requests high.
        applyStimulus(mk(1, 1, 1, 9'h011, 16'hBEEF, 1, 1, 9'h022, 16'hCAFE,
                         0, 0, 0, 1, 0, 9'h000, 16'h0, 16'h0, 16'h0));
        tick();
        checkReset("rst_c1");
        tick();
        checkReset("rst_c2");
        applyStimulus(mk(0, 0, 0, 9'h000, 16'h0, 0, 0, 9'h000, 16'h0,
                         0, 0, 0, 1, 0, 9'h000, 16'h0, 16'h0, 16'h0));
        tick();
        checkReset("rst_rel");

        // Table: write/read, tie after reset, cross-visibility at boundary addresses.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("v%0d_ack0", i),   32'(bus.ack0),     32'(vecs[i].eAck0));
            checkOutput($sformatf("v%0d_ack1", i),   32'(bus.ack1),     32'(vecs[i].eAck1));
            checkOutput($sformatf("v%0d_busy", i),   32'(bus.busy),     32'(vecs[i].eBusy));
            checkOutput($sformatf("v%0d_owner", i),  32'(bus.owner),    32'(vecs[i].eOwner));
            checkOutput($sformatf("v%0d_load", i),   32'(bus.ram_load), 32'(vecs[i].eLoad));
            checkOutput($sformatf("v%0d_addr", i),   32'(bus.ram_addr), 32'(vecs[i].eAddr));
            if (vecs[i].eLoad)
                checkOutput($sformatf("v%0d_in", i), 32'(bus.ram_in),   32'(vecs[i].eIn));
            checkOutput($sformatf("v%0d_rdata0", i), 32'(bus.rdata0),   32'(vecs[i].eRd0));
            checkOutput($sformatf("v%0d_rdata1", i), 32'(bus.rdata1),   32'(vecs[i].eRd1));
        end

        // Round-robin: both reads held for 12 cycles; owner is 1 so requester 0 goes first.
        nAcks = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 9'h1FF; bus.wdata0 = 16'h0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 9'h000; bus.wdata1 = 16'h0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (bus.ack0 && bus.ack1)
                checkOutput($sformatf("rr_both_ack_c%0d", c), 32'd1, 32'd0);
            if ((bus.ack0 || bus.ack1) && nAcks < 4) begin
                ackCycle[nAcks] = c;
                ackOwner[nAcks] = bus.ack1 ? 1 : 0;
                checkOutput($sformatf("rr_owner_pin%0d", nAcks), 32'(bus.owner), 32'(ackOwner[nAcks]));
                nAcks++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checkOutput("rr_ack_count", 32'(nAcks), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < nAcks) begin
                checkOutput($sformatf("rr_ack%0d_owner", k), 32'(ackOwner[k]), 32'(k % 2));
                checkOutput($sformatf("rr_ack%0d_cycle", k), 32'(ackCycle[k]), 32'(2 + 3 * k));
            end
        end
        checkOutput("rr_rdata0", 32'(bus.rdata0), 32'h00AA);
        checkOutput("rr_rdata1", 32'(bus.rdata1), 32'h0055);
        tick();
        checkOutput("rr_idle_busy", 32'(bus.busy), 32'd0);

        // Reset during GRANT of a write: write still commits, no ack, rdata cleared.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 9'h010; bus.wdata0 = 16'h7777;
        tick();
        checkOutput("rg_grant_load", 32'(bus.ram_load), 32'd1);
        checkOutput("rg_grant_addr", 32'(bus.ram_addr), 32'h010);
        reset = 1'b1;
        bus.req0 = 1'b0;
        tick();
        checkOutput("rg_ack0",   32'(bus.ack0),     32'd0);
        checkOutput("rg_load",   32'(bus.ram_load), 32'd0);
        checkOutput("rg_busy",   32'(bus.busy),     32'd0);
        checkOutput("rg_rdata0", 32'(bus.rdata0),   32'd0);
        checkOutput("rg_rdata1", 32'(bus.rdata1),   32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rg_after_ack0", 32'(bus.ack0),     32'd0);
        checkOutput("rg_after_load", 32'(bus.ram_load), 32'd0);
        checkOutput("rg_after_busy", 32'(bus.busy),     32'd0);

        // Later read of the interrupted write's address by requester 1.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 9'h010;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (bus.ack1) seen = 1'b1;
        end
        bus.req1 = 1'b0;
        if (!seen) checkOutput("rg_read_timeout", 32'd0, 32'd1);
        checkOutput("rg_read_rdata1", 32'(bus.rdata1), 32'h7777);
        tick();

        // Reset during ACK truncates the pulse.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 9'h005;
        tick();
        tick();
        checkOutput("ra_ack0_on", 32'(bus.ack0), 32'd1);
        bus.req0 = 1'b0;
        reset = 1'b1;
        tick();
        checkOutput("ra_ack0_off", 32'(bus.ack0), 32'd0);
        checkOutput("ra_rdata0",   32'(bus.rdata0), 32'd0);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/my_ram_arbiter.md
# my_ram_arbiter

Two-port round-robin arbiter and access sequencer for one shared `my_ram_512` (512 x 16, write on rising `clk` when `load` is high, combinational read of `out`). Two requesters issue single-word read or write requests over a req/ack handshake. The block owns the RAM's `in`, `addr` and `load` pins, serialises accesses, and returns registered read data per requester.

## Interface
- `ADDR_W`, 9, address width; must match the RAM.
- `DATA_W`, 16, data width; must match the RAM.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0` / `req1`  in  1  access request, held until the matching ack.
- `we0` / `we1`  in  1  1 = write, 0 = read; sampled with req.
- `addr0` / `addr1`  in  ADDR_W  word address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  read result; valid from the ack cycle, held until the next read by the same requester.
- `busy`  out  1  high in GRANT and ACK.
- `owner`  out  1  requester index of the current or most recent grant.
- `ram_in`  out  DATA_W  to RAM `in`.
- `ram_addr`  out  ADDR_W  to RAM `addr`.
- `ram_load`  out  1  to RAM `load`.
- `ram_out`  in  DATA_W  from RAM `out`.

## Operation
- FSM states: IDLE, GRANT, ACK. All outputs are registered.
- **IDLE:** `ram_load` = 0.
  - No req: stay in IDLE.
  - One req: grant that requester.
  - Both reqs: grant the requester that is not `owner`.
  - On a grant, latch the winner's we/addr/wdata into `ram_load`/`ram_addr`/`ram_in`, set `owner`, go to GRANT.
- **GRANT:** RAM is driven for exactly one cycle.
  - Write: `ram_load` = 1 and the RAM commits at the closing edge.
  - Read: `rdata<owner>` captures `ram_out` at the closing edge.
  - Next state: ACK, with `ram_load` cleared.
- **ACK:** `ack<owner>` = 1 for this cycle only; the other ack stays 0. Next state: IDLE.
- Requester rule: req must be low at the edge that ends its ack cycle unless it wants another access. A req still high in the following IDLE cycle is a new request.
- A write never updates either rdata register. A read updates only the owner's rdata.
- Requests arriving while `busy` wait; they are not dropped.
- Fairness: with both reqs held continuously, grants strictly alternate.
- Address is used as given: 9'h1FF and 9'h000 are distinct words, with no wrap arithmetic.

## Timing
- Reset values: state IDLE; `ack0`/`ack1` 0; `rdata0`/`rdata1` 0; `ram_load` 0; `ram_addr` 0; `ram_in` 0; `busy` 0; `owner` 1, so requester 0 wins the first tie.
- Latency: req sampled high at edge k -> GRANT during cycle k+1 -> ack high during cycle k+2 -> IDLE from edge k+3.
- Throughput: one access per 3 cycles.
- Read data is visible on `rdata` in the same cycle as the ack.
- Simultaneous reqs in IDLE: exactly one grant. The loser's request is served on the next IDLE.
- Reset during GRANT:
  - A write already driven still commits at that edge, because the RAM has no reset.
  - No ack is issued, and the rdata registers are cleared to 0.
  - State returns to IDLE with `ram_load` = 0 from the next cycle.
- Reset during ACK: the ack pulse is truncated to 0 from the next cycle.
- Reset has priority over any req.

## Test plan
- **Reset:** assert reset for 2 cycles with both reqs high -> all outputs at their reset values, no ack, `ram_load` 0.
- **Single requester write then read:** req0 writes 16'h1234 to 9'h005 -> `ram_load` high for exactly one cycle, ack0 two cycles after req is sampled. Then req0 reads 9'h005 -> `rdata0` = 16'h1234 in the ack0 cycle, with `rdata1` unchanged.
- **Tie after reset:** req0 writes 16'd2 to 9'h000 and req1 writes 16'd9 to 9'h1A7, both asserted in the same cycle -> ack0 precedes ack1 by 3 cycles. Subsequent reads return 2 and 9.
- **Round-robin:** both reqs held for 4 accesses -> owner sequence 0,1,0,1 with acks 3 cycles apart and never simultaneous.
- **Cross-visibility and boundary addresses:**
  - req1 writes 16'h00AA to 9'h1FF, then req0 writes 16'h0055 to 9'h000.
  - req0 reads 9'h1FF -> `rdata0` = 16'h00AA.
  - req1 reads 9'h000 -> `rdata1` = 16'h0055.
- **Reset mid-GRANT on a write of 16'h7777 to 9'h010:** no ack, FSM in IDLE, `ram_load` 0 on the following cycle. A later read of 9'h010 returns 16'h7777.
